ib_update_queue: RTL and testbench

//  Producer side of the indirect-branch update bus. Collects resolved indirect jumps from the branch units and holds each one until it commits.

---
 rtl/ib_update_queue.sv | 163 ++++++++++++++++
 tb/tb_ib_update_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_update_queue.sv
// Indirect-branch update queue: holds resolved indirect jumps until commit, emits committed ones to the predictor.
// Latency: an input sampled at edge t can appear on OUT_ibUpdates after edge t+1 when it is already committed.
// Backpressure: none in either direction; surplus inputs are dropped and counted, and the predictor always accepts.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   IN_clearICache  invalidate every entry and the output register (drop counter kept)
//   IN_br*          NUM_IN resolution ports: valid, indirect, src PC[31:1], dst PC[31:1], sqN
//   IN_flush*       mispredict flush; entries strictly younger than IN_flushSqN die
//   IN_comSqN       oldest uncommitted sqN; entries older than it are committed
//   OUT_ibUpdates   NUM_UPDATES packets of {src[30:0], dst[30:0], valid}
//   OUT_dropCnt     saturating count of inputs lost to a full queue
module ib_update_queue #(
  parameter int NUM_IN      = 2,
  parameter int NUM_UPDATES = 2,
  parameter int DEPTH       = 8,
  parameter int SQN_W       = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IN_clearICache,
  input  logic [NUM_IN-1:0]         IN_brValid,
  input  logic [NUM_IN-1:0]         IN_brIndirect,
  input  logic [NUM_IN*31-1:0]      IN_brSrc,
  input  logic [NUM_IN*31-1:0]      IN_brDst,
  input  logic [NUM_IN*SQN_W-1:0]   IN_brSqN,
  input  logic                      IN_flushValid,
  input  logic [SQN_W-1:0]          IN_flushSqN,
  input  logic [SQN_W-1:0]          IN_comSqN,
  output logic [NUM_UPDATES*63-1:0] OUT_ibUpdates,
  output logic [15:0]               OUT_dropCnt
);

  localparam int PKT_W  = 63;
  localparam int DROP_W = $clog2(NUM_IN + 1);

  typedef struct packed {
    logic [30:0]      src;
    logic [30:0]      dst;
    logic [SQN_W-1:0] sqn;
  } entry_t;

  // Wrap-safe age compares: the difference is read as a signed SQN_W-bit value.
  function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[SQN_W-1];
  endfunction

  function automatic logic committed(input logic [SQN_W-1:0] e, input logic [SQN_W-1:0] com);
    logic [SQN_W-1:0] diff;
    diff = e - com;
    return diff[SQN_W-1];
  endfunction

  // State
  logic [DEPTH-1:0]         valid_q, valid_d;
  entry_t                   entry_q [DEPTH];
  entry_t                   entry_d [DEPTH];
  logic [NUM_UPDATES*63-1:0] upd_q, upd_d;
  logic [15:0]              drop_q, drop_d;

  // Per-slot classification
  logic [DEPTH-1:0]         kill;       // removed by this cycle's flush
  logic [DEPTH-1:0]         emit_ok;    // committed and surviving the flush
  logic [DEPTH-1:0]         sel;        // chosen for emission this cycle
  logic [DEPTH-1:0]         free;       // slots still available to incoming ports
  logic [DROP_W-1:0]        n_drop;
  logic [16:0]              drop_sum;

  always_comb begin
    kill    = '0;
    emit_ok = '0;
    for (int s = 0; s < DEPTH; s++) begin
      kill[s]    = valid_q[s] & IN_flushValid & younger(entry_q[s].sqn, IN_flushSqN);
      emit_ok[s] = valid_q[s] & ~kill[s] & committed(entry_q[s].sqn, IN_comSqN);
    end
  end

  // Emission: first NUM_UPDATES eligible slots by index fill packets 0..NUM_UPDATES-1.
  always_comb begin
    int n_sel;
    sel   = '0;
    upd_d = '0;
    n_sel = 0;
    for (int s = 0; s < DEPTH; s++) begin
      if (emit_ok[s] && (n_sel < NUM_UPDATES)) begin
        sel[s] = 1'b1;
        upd_d[n_sel*PKT_W +: PKT_W] = {entry_q[s].src, entry_q[s].dst, 1'b1};
        n_sel = n_sel + 1;
      end
    end
  end

  // Enqueue: free slots come from the registered valids only, so a slot
  // vacated this cycle (emitted or flushed) is not handed out until next cycle.
  always_comb begin
    logic             placed;
    logic             cand;
    logic [SQN_W-1:0] in_sqn;
    free    = ~valid_q;
    valid_d = valid_q & ~kill & ~sel;
    entry_d = entry_q;
    n_drop  = '0;
    placed  = 1'b0;
    cand    = 1'b0;
    in_sqn  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_sqn = IN_brSqN[i*SQN_W +: SQN_W];
      // Inputs killed by a same-cycle flush are neither queued nor counted.
      cand   = IN_brValid[i] & IN_brIndirect[i] &
               ~(IN_flushValid & younger(in_sqn, IN_flushSqN));
      placed = 1'b0;
      if (cand) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (!placed && free[s]) begin
            placed         = 1'b1;
            free[s]        = 1'b0;
            valid_d[s]     = 1'b1;
            entry_d[s].src = IN_brSrc[i*31 +: 31];
            entry_d[s].dst = IN_brDst[i*31 +: 31];
            entry_d[s].sqn = in_sqn;
          end
        end
        if (!placed) begin
          n_drop = n_drop + DROP_W'(1);
        end
      end
    end
  end

  // Saturating drop counter
  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Control state: reset clears everything; cache clear keeps the drop count
  // and discards whatever arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      upd_q   <= '0;
      drop_q  <= '0;
    end else if (IN_clearICache) begin
      valid_q <= '0;
      upd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      upd_q   <= upd_d;
      drop_q  <= drop_d;
    end
  end

  // Payload is only meaningful under valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign OUT_ibUpdates = upd_q;
  assign OUT_dropCnt   = drop_q;

endmodule

// File: tb/tb_ib_update_queue.sv
// Bench for ib_update_queue: directed scenarios with literal expectations plus
// a slot-level behavioural model checked after every clock edge.
module tb_ib_update_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [1:0]   br_v;
  logic [1:0]   br_ind;
  logic [61:0]  br_src;
  logic [61:0]  br_dst;
  logic [13:0]  br_sq;
  logic         fv;
  logic [6:0]   fsq;
  logic [6:0]   com;
  logic [125:0] OUT_ibUpdates;
  logic [15:0]  OUT_dropCnt;

  always #5 clk = ~clk;

  ib_update_queue #(.NUM_IN(2), .NUM_UPDATES(2), .DEPTH(8), .SQN_W(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_clearICache (clr),
    .IN_brValid     (br_v),
    .IN_brIndirect  (br_ind),
    .IN_brSrc       (br_src),
    .IN_brDst       (br_dst),
    .IN_brSqN       (br_sq),
    .IN_flushValid  (fv),
    .IN_flushSqN    (fsq),
    .IN_comSqN      (com),
    .OUT_ibUpdates  (OUT_ibUpdates),
    .OUT_dropCnt    (OUT_dropCnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [125:0] act, input logic [125:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [62:0] pkt(input logic [30:0] s, input logic [30:0] d);
    return {s, d, 1'b1};
  endfunction

  // ---------------- behavioural model ----------------
  // Sequence numbers live on a 128-value circle; "younger" means 1..63 ahead.
  function automatic bit m_younger(input int a, input int b);
    int d;
    d = (a - b) & 127;
    return (d >= 1) && (d <= 63);
  endfunction

  function automatic bit m_committed(input int e, input int c);
    return ((e - c) & 127) >= 64;
  endfunction

  bit           m_v   [8];
  logic [30:0]  m_src [8];
  logic [30:0]  m_dst [8];
  int           m_sq  [8];
  logic [125:0] exp_out  = '0;
  int           exp_drop = 0;

  always @(posedge clk) begin : model
    bit sv [8];
    int n;
    int drops;
    int q;
    int s;
    int freeq [$];
    if (rst) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      exp_out  = '0;
      exp_drop = 0;
    end else if (clr) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      exp_out = '0;
    end else begin
      sv      = m_v;
      exp_out = '0;
      n       = 0;
      drops   = 0;
      freeq.delete();
      for (int k = 0; k < 8; k++) begin
        if (m_v[k]) begin
          if (fv && m_younger(m_sq[k], int'(fsq))) begin
            m_v[k] = 1'b0;
          end else if (m_committed(m_sq[k], int'(com)) && n < 2) begin
            exp_out[n*63 +: 63] = pkt(m_src[k], m_dst[k]);
            n++;
            m_v[k] = 1'b0;
          end
        end
      end
      for (int k = 0; k < 8; k++) if (!sv[k]) freeq.push_back(k);
      for (int p = 0; p < 2; p++) begin
        if (br_v[p] && br_ind[p]) begin
          q = int'(br_sq[p*7 +: 7]);
          if (!(fv && m_younger(q, int'(fsq)))) begin
            if (freeq.size() > 0) begin
              s        = freeq.pop_front();
              m_v[s]   = 1'b1;
              m_src[s] = br_src[p*31 +: 31];
              m_dst[s] = br_dst[p*31 +: 31];
              m_sq[s]  = q;
            end else begin
              drops++;
            end
          end
        end
      end
      exp_drop = (exp_drop + drops > 65535) ? 65535 : exp_drop + drops;
    end
  end

  // Compare every cycle, just after the edge has settled.
  always @(posedge clk) begin
    #1;
    chk("cyc_out", OUT_ibUpdates, exp_out);
    chk("cyc_drop", {110'b0, OUT_dropCnt}, 126'(exp_drop));
  end

  // ---------------- stimulus ----------------
  task automatic set_br(input int p, input logic [30:0] s, input logic [30:0] d,
                        input logic [6:0] q, input bit ind);
    br_v[p]             = 1'b1;
    br_ind[p]           = ind;
    br_src[p*31 +: 31]  = s;
    br_dst[p*31 +: 31]  = d;
    br_sq[p*7 +: 7]     = q;
  endtask

  // Advance to the next falling edge (one rising edge consumed) and drop
  // single-cycle strobes.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      br_v   = '0;
      br_ind = '0;
      fv     = 1'b0;
      clr    = 1'b0;
    end
  endtask

  initial begin
    int tmp;
    rst = 1'b1; clr = 1'b0; br_v = '0; br_ind = '0; br_src = '0; br_dst = '0;
    br_sq = '0; fv = 1'b0; fsq = '0; com = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out", OUT_ibUpdates, '0);
    chk("reset_drop", {110'b0, OUT_dropCnt}, '0);

    // 1: committed entry appears two edges after sampling, then clears
    com = 7'd6;
    set_br(0, 31'h100, 31'h2000, 7'd5, 1'b1);
    tick();
    chk("t1_not_yet", OUT_ibUpdates, '0);
    tick();
    chk("t1_packet", OUT_ibUpdates, {63'b0, pkt(31'h100, 31'h2000)});
    tick();
    chk("t1_after", OUT_ibUpdates, '0);

    // 2: held until commit, then one edge later; wrap-around commit
    com = 7'd8;
    set_br(0, 31'h111, 31'h222, 7'd10, 1'b1);
    tick(3);
    chk("t2_held", OUT_ibUpdates, '0);
    com = 7'd11;
    tick();
    chk("t2_commit", OUT_ibUpdates, {63'b0, pkt(31'h111, 31'h222)});
    com = 7'd2;
    set_br(1, 31'h333, 31'h444, 7'd126, 1'b1);
    tick(2);
    chk("t2_wrap", OUT_ibUpdates, {63'b0, pkt(31'h333, 31'h444)});
    tick();

    // 3: fill, overflow by two, then drain two per cycle
    com = 7'd0;
    for (int j = 0; j < 4; j++) begin
      set_br(0, 31'(16 + 2*j), 31'(32 + 2*j), 7'(10 + 2*j), 1'b1);
      set_br(1, 31'(17 + 2*j), 31'(33 + 2*j), 7'(11 + 2*j), 1'b1);
      tick();
    end
    set_br(0, 31'h7a, 31'h7b, 7'd30, 1'b1);
    set_br(1, 31'h7c, 31'h7d, 7'd31, 1'b1);
    tick();
    chk("t3_drop", {110'b0, OUT_dropCnt}, 126'd2);
    com = 7'd20;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t3_burst", OUT_ibUpdates,
          {pkt(31'(17 + 2*j), 31'(33 + 2*j)), pkt(31'(16 + 2*j), 31'(32 + 2*j))});
    end
    tick();
    chk("t3_empty", OUT_ibUpdates, '0);

    // 4: flush kills younger entries and a same-cycle younger input
    com = 7'd0;
    set_br(0, 31'h31, 31'h41, 7'd3, 1'b1);
    set_br(1, 31'h32, 31'h42, 7'd4, 1'b1);
    tick();
    set_br(0, 31'h33, 31'h43, 7'd5, 1'b1);
    tick();
    fv = 1'b1; fsq = 7'd3;
    set_br(1, 31'h34, 31'h44, 7'd6, 1'b1);
    tick();
    chk("t4_drop_same", {110'b0, OUT_dropCnt}, 126'd2);
    com = 7'd10;
    tick();
    chk("t4_survivor", OUT_ibUpdates, {63'b0, pkt(31'h31, 31'h41)});
    tick();
    chk("t4_only_one", OUT_ibUpdates, '0);

    // 5: clear beats commit; drop count survives clear but not reset
    com = 7'd0;
    set_br(0, 31'h51, 31'h61, 7'd40, 1'b1);
    set_br(1, 31'h52, 31'h62, 7'd41, 1'b1);
    tick();
    set_br(0, 31'h53, 31'h63, 7'd42, 1'b1);
    tick();
    com = 7'd50; clr = 1'b1;
    tick();
    chk("t5_clear_out", OUT_ibUpdates, '0);
    tick(2);
    chk("t5_gone", OUT_ibUpdates, '0);
    chk("t5_drop_kept", {110'b0, OUT_dropCnt}, 126'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_drop_rst", {110'b0, OUT_dropCnt}, '0);

    // 6: non-indirect ignored; dual-port commit lands in port order
    set_br(0, 31'h71, 31'h81, 7'd45, 1'b0);
    tick(2);
    chk("t6_nonind", OUT_ibUpdates, '0);
    set_br(0, 31'h72, 31'h82, 7'd46, 1'b1);
    set_br(1, 31'h73, 31'h83, 7'd47, 1'b1);
    tick(2);
    chk("t6_pair", OUT_ibUpdates, {pkt(31'h73, 31'h83), pkt(31'h72, 31'h82)});
    tick();

    // Mixed traffic, checked by the model only
    for (int c = 0; c < 400; c++) begin
      com = 7'(int'(com) + $urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          tmp = int'(com) + $urandom_range(0, 24) - 6;
          set_br(p, 31'($urandom), 31'($urandom), 7'(tmp), $urandom_range(0, 5) != 0);
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        fv  = 1'b1;
        fsq = 7'(int'(com) + $urandom_range(0, 10));
      end
      if ($urandom_range(0, 99) == 0) clr = 1'b1;
      tick();
    end
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
